alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid in 1, in_ready out 1; decode-side valid/ready handshake.
REQ-004 SHALL have ports: in_rs1_addr, in_rs2_addr, in_rd_addr  in  3 each; register indices, r0 hardwired zero.
REQ-005 SHALL have ports: in_rs1_data, in_rs2_data, in_imm  in  16 each; register-file read data and sign-extended immediate.
REQ-006 SHALL have ports: in_use_imm in 1 (b := imm), in_alu_ctrl in 3 (ALU opcode, 000 ADD..101 SLT), in_rd_we in 1.
REQ-007 SHALL have ports: exm_we in 1, exm_is_load in 1, exm_rd in 3, exm_data in 16; EX/MEM forwarding source.
REQ-008 SHALL have ports: wb_we in 1, wb_rd in 3, wb_data in 16; MEM/WB forwarding source.
REQ-009 SHALL have ports: flush in 1; synchronous squash from branch resolution.
REQ-010 SHALL have ports: out_valid out 1, out_ready in 1; ALU-side handshake.
REQ-011 SHALL have ports: alu_a, alu_b out 16; alu_ctrl_o out 3; out_rd_addr out 3; out_rd_we out 1; registered ALU operands and tag.
REQ-012 SHALL have ports: hazard_cnt out 16; saturating load-use stall counter.

Function
REQ-013 SHALL define hit_exm(r) = exm_we & (exm_rd==r) & (r!=0); hit_wb(r) = wb_we & (wb_rd==r) & (r!=0).
REQ-014 SHALL select operand for source r: r==0 -> 0; else hit_exm -> exm_data; else hit_wb -> wb_data; else register data (EX/MEM priority over WB).
REQ-015 SHALL compute b-operand as in_imm when in_use_imm=1, ignoring rs2 entirely (no forwarding, no hazard on rs2).
REQ-016 SHALL assert hazard = in_valid & exm_is_load & (hit_exm(rs1) | (!in_use_imm & hit_exm(rs2))).
REQ-017 SHALL drive in_ready = !hazard & !flush & (!out_valid | out_ready), combinationally.
REQ-018 SHALL accept (in_valid & in_ready) by loading alu_a, alu_b, alu_ctrl_o, out_rd_addr, out_rd_we with the forwarded values and setting out_valid=1 next cycle; latency 1 cycle.
REQ-019 SHALL clear out_valid on out_valid & out_ready with no accept in the same cycle; simultaneous drain and accept keeps out_valid=1 with new contents (full throughput).
REQ-020 SHALL hold all output registers stable while out_valid=1 and out_ready=0.
REQ-021 SHALL on flush=1 clear out_valid and out_rd_we next cycle, deassert in_ready, and accept nothing; flush overrides every simultaneous accept or drain.
REQ-022 SHALL leave data registers unchanged on flush (only valid/we cleared).
REQ-023 SHALL increment hazard_cnt by 1 each cycle hazard=1 and flush=0, saturating at 0xFFFF (no wrap).
REQ-024 SHALL treat captured operands as final; forwarding sources changing while output is held have no effect.

Reset
REQ-025 SHALL on rst_n=0 immediately force out_valid=0, alu_a=alu_b=0, alu_ctrl_o=000, out_rd_addr=0, out_rd_we=0, hazard_cnt=0, independent of clk.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset release when flush=0 and no hazard.
REQ-027 SHALL discard any in-flight instruction when reset asserts mid-operation; no partial state survives.

Verification
REQ-028 SHALL cover forwarding priority: rs1=3, rs1_data=0x0001, exm(we,rd=3,0x00AA), wb(we,rd=3,0x00BB) -> alu_a=0x00AA next cycle; drop exm_we -> 0x00BB.
REQ-029 SHALL cover r0: rs1=0, exm(we,rd=0,0x1234) -> alu_a=0x0000, no hazard even with exm_is_load=1.
REQ-030 SHALL cover load-use: exm_is_load=1, exm_rd=5, rs2=5, use_imm=0 -> in_ready=0 one cycle, hazard_cnt=1; same with use_imm=1 -> no stall, alu_b=imm.
REQ-031 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> drain and new accept same cycle.
REQ-032 SHALL cover flush: flush=1 with in_valid=1, out_valid=1 -> out_valid=0 next cycle, no accept.
REQ-033 SHALL cover saturation and reset: 0x10000 hazard cycles -> hazard_cnt=0xFFFF; rst_n low mid-transfer -> all outputs zero without clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves operand forwarding from EX/MEM and MEM/WB, stalls on load-use,
// and registers one instruction's operands behind a valid/ready skid-free output slot.
module alu_issue_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_rs1_addr,
   input  logic [2:0]  in_rs2_addr,
   input  logic [2:0]  in_rd_addr,
   input  logic [15:0] in_rs1_data,
   input  logic [15:0] in_rs2_data,
   input  logic [15:0] in_imm,
   input  logic        in_use_imm,
   input  logic [2:0]  in_alu_ctrl,
   input  logic        in_rd_we,
   input  logic        exm_we,
   input  logic        exm_is_load,
   input  logic [2:0]  exm_rd,
   input  logic [15:0] exm_data,
   input  logic        wb_we,
   input  logic [2:0]  wb_rd,
   input  logic [15:0] wb_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_ctrl_o,
   output logic [2:0]  out_rd_addr,
   output logic        out_rd_we,
   output logic [15:0] hazard_cnt
);

   logic        exm_hit_rs1, exm_hit_rs2, wb_hit_rs1, wb_hit_rs2;
   logic        hazard, accept;
   logic [15:0] fwd_a, fwd_b;

   assign exm_hit_rs1 = exm_we & (exm_rd == in_rs1_addr) & (in_rs1_addr != 3'd0);
   assign exm_hit_rs2 = exm_we & (exm_rd == in_rs2_addr) & (in_rs2_addr != 3'd0);
   assign wb_hit_rs1  = wb_we  & (wb_rd  == in_rs1_addr) & (in_rs1_addr != 3'd0);
   assign wb_hit_rs2  = wb_we  & (wb_rd  == in_rs2_addr) & (in_rs2_addr != 3'd0);

   // A load in EX/MEM has no data yet, so a dependent instruction must wait a cycle.
   assign hazard   = in_valid & exm_is_load & (exm_hit_rs1 | (~in_use_imm & exm_hit_rs2));
   assign in_ready = ~hazard & ~flush & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   // NOTE: every branch of a combinational block must assign each output, so defaults come first to avoid latches.
   always_comb begin
      fwd_a = in_rs1_data;
      if (in_rs1_addr == 3'd0) fwd_a = 16'd0;
      else if (exm_hit_rs1)    fwd_a = exm_data;
      else if (wb_hit_rs1)     fwd_a = wb_data;
   end

   always_comb begin
      fwd_b = in_rs2_data;
      if (in_use_imm)               fwd_b = in_imm;
      else if (in_rs2_addr == 3'd0) fwd_b = 16'd0;
      else if (exm_hit_rs2)         fwd_b = exm_data;
      else if (wb_hit_rs2)          fwd_b = wb_data;
   end

   // NOTE: the payload registers are reset too, so no stale operands are visible after reset;
   // non-blocking assignments keep all state updates on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         alu_a       <= 16'd0;
         alu_b       <= 16'd0;
         alu_ctrl_o  <= 3'd0;
         out_rd_addr <= 3'd0;
         out_rd_we   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_rd_we <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         alu_a       <= fwd_a;
         alu_b       <= fwd_b;
         alu_ctrl_o  <= in_alu_ctrl;
         out_rd_addr <= in_rd_addr;
         out_rd_we   <= in_rd_we;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hazard_cnt <= 16'd0;
      end else if (hazard && !flush && hazard_cnt != 16'hFFFF) begin
         hazard_cnt <= hazard_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a transaction-level model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [15:0] in_rs1_data, in_rs2_data, in_imm;
   logic        in_use_imm, in_rd_we;
   logic [2:0]  in_alu_ctrl;
   logic        exm_we, exm_is_load;
   logic [2:0]  exm_rd;
   logic [15:0] exm_data;
   logic        wb_we;
   logic [2:0]  wb_rd;
   logic [15:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_ctrl_o, out_rd_addr;
   logic        out_rd_we;
   logic [15:0] hazard_cnt;

   int n_checks = 0;
   int n_errors = 0;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl), .in_rd_we(in_rd_we),
      .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl_o(alu_ctrl_o),
      .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
      .hazard_cnt(hazard_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: one-entry output slot described as a transaction ----------------
   int          m_valid;
   logic [15:0] m_a, m_b;
   logic [2:0]  m_ctrl, m_rd;
   logic        m_we;
   int          m_cnt;

   function automatic logic [15:0] operand(input logic [2:0] r, input logic [15:0] regval);
      if (r == 3'd0) return 16'd0;
      if (exm_we && exm_rd == r) return exm_data;
      if (wb_we && wb_rd == r) return wb_data;
      return regval;
   endfunction

   function automatic bit waits_on_load(input logic [2:0] r);
      return exm_is_load && exm_we && r != 3'd0 && exm_rd == r;
   endfunction

   function automatic bit stall();
      return in_valid && (waits_on_load(in_rs1_addr) || (!in_use_imm && waits_on_load(in_rs2_addr)));
   endfunction

   function automatic bit model_ready();
      return !stall() && !flush && (m_valid == 0 || out_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit take, drain;
      if (!rst_n) begin
         m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_we = 0; m_cnt = 0;
      end else begin
         take  = in_valid && model_ready();
         drain = (m_valid != 0) && out_ready;
         if (!flush && stall()) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
         if (flush) begin
            m_valid = 0;
            m_we    = 0;
         end else if (take) begin
            m_valid = 1;
            m_a     = operand(in_rs1_addr, in_rs1_data);
            m_b     = in_use_imm ? in_imm : operand(in_rs2_addr, in_rs2_data);
            m_ctrl  = in_alu_ctrl;
            m_rd    = in_rd_addr;
            m_we    = in_rd_we;
         end else if (drain) begin
            m_valid = 0;
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      check("m_out_valid", {31'd0, out_valid}, m_valid);
      check("m_alu_a", {16'd0, alu_a}, {16'd0, m_a});
      check("m_alu_b", {16'd0, alu_b}, {16'd0, m_b});
      check("m_alu_ctrl", {29'd0, alu_ctrl_o}, {29'd0, m_ctrl});
      check("m_rd_addr", {29'd0, out_rd_addr}, {29'd0, m_rd});
      check("m_rd_we", {31'd0, out_rd_we}, {31'd0, m_we});
      check("m_hazard_cnt", {16'd0, hazard_cnt}, m_cnt);
      check("m_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] rs1, input logic [15:0] d1, input logic [2:0] rs2,
                        input logic [15:0] d2, input logic use_imm, input logic [15:0] imm,
                        input logic [2:0] ctrl, input logic [2:0] rd, input logic we);
      in_valid = 1'b1;
      in_rs1_addr = rs1; in_rs1_data = d1;
      in_rs2_addr = rs2; in_rs2_data = d2;
      in_use_imm = use_imm; in_imm = imm;
      in_alu_ctrl = ctrl; in_rd_addr = rd; in_rd_we = we;
   endtask

   task automatic set_exm(input logic we, input logic ld, input logic [2:0] rd, input logic [15:0] d);
      exm_we = we; exm_is_load = ld; exm_rd = rd; exm_data = d;
   endtask

   task automatic set_wb(input logic we, input logic [2:0] rd, input logic [15:0] d);
      wb_we = we; wb_rd = rd; wb_data = d;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 0; flush = 0; out_ready = 1;
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 0;
      set_exm(0, 0, 0, 0);
      set_wb(0, 0, 0);
      #2;
      check("reset_out_valid", {31'd0, out_valid}, 0);
      check("reset_alu_a", {16'd0, alu_a}, 0);
      check("reset_hazard_cnt", {16'd0, hazard_cnt}, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      tick();
      check("ready_after_reset", {31'd0, in_ready}, 1);

      // Forwarding priority: EX/MEM over WB over register file.
      issue(3, 16'h0001, 0, 16'h9999, 0, 0, 3'b000, 4, 1);
      set_exm(1, 0, 3, 16'h00AA);
      set_wb(1, 3, 16'h00BB);
      tick();
      check("fwd_exm", {16'd0, alu_a}, 32'h00AA);
      check("fwd_valid", {31'd0, out_valid}, 1);
      check("fwd_rs2_zero", {16'd0, alu_b}, 0);
      exm_we = 0;
      tick();
      check("fwd_wb", {16'd0, alu_a}, 32'h00BB);
      wb_we = 0;
      tick();
      check("fwd_reg", {16'd0, alu_a}, 32'h0001);

      // r0 is never forwarded and never stalls.
      issue(0, 16'h5555, 0, 0, 1, 16'h0042, 3'b001, 1, 1);
      set_exm(1, 1, 0, 16'h1234);
      #1;
      check("r0_no_hazard", {31'd0, in_ready}, 1);
      tick();
      check("r0_alu_a", {16'd0, alu_a}, 0);
      check("r0_alu_b_imm", {16'd0, alu_b}, 32'h0042);

      // Load-use on rs2 stalls exactly while the load sits in EX/MEM.
      issue(1, 16'h0003, 5, 16'h0004, 0, 0, 3'b101, 2, 1);
      set_exm(1, 1, 5, 16'hDEAD);
      #1;
      check("loaduse_stall", {31'd0, in_ready}, 0);
      tick();
      check("loaduse_cnt", {16'd0, hazard_cnt}, 1);
      set_exm(0, 0, 0, 0);
      set_wb(1, 5, 16'h0777);
      #1;
      check("loaduse_release", {31'd0, in_ready}, 1);
      tick();
      check("loaduse_wb_b", {16'd0, alu_b}, 32'h0777);
      set_wb(0, 0, 0);
      issue(1, 16'h0003, 5, 16'h0004, 1, 16'h7777, 3'b011, 2, 1);
      set_exm(1, 1, 5, 16'hDEAD);
      #1;
      check("imm_no_stall", {31'd0, in_ready}, 1);
      tick();
      check("imm_alu_b", {16'd0, alu_b}, 32'h7777);
      check("imm_cnt_same", {16'd0, hazard_cnt}, 1);
      set_exm(0, 0, 0, 0);

      // Backpressure: held contents ignore forwarding changes; drain+accept in one cycle.
      out_ready = 0;
      issue(2, 16'h1111, 3, 16'h2222, 0, 0, 3'b010, 6, 0);
      #1;
      check("bp_not_ready", {31'd0, in_ready}, 0);
      for (int i = 0; i < 3; i++) begin
         set_exm(1, 0, 2, 16'hBAD0 + 16'(i));
         tick();
         check("bp_hold_b", {16'd0, alu_b}, 32'h7777);
         check("bp_hold_valid", {31'd0, out_valid}, 1);
      end
      set_exm(0, 0, 0, 0);
      out_ready = 1;
      #1;
      check("bp_ready", {31'd0, in_ready}, 1);
      tick();
      check("bp_new_a", {16'd0, alu_a}, 32'h1111);
      check("bp_new_b", {16'd0, alu_b}, 32'h2222);
      check("bp_new_ctrl", {29'd0, alu_ctrl_o}, 32'd2);
      check("bp_new_valid", {31'd0, out_valid}, 1);

      // Flush beats an accept and a hazard; payload stays.
      issue(4, 16'h3333, 0, 0, 0, 0, 3'b100, 7, 1);
      flush = 1;
      #1;
      check("flush_not_ready", {31'd0, in_ready}, 0);
      tick();
      check("flush_valid", {31'd0, out_valid}, 0);
      check("flush_we", {31'd0, out_rd_we}, 0);
      check("flush_keep_a", {16'd0, alu_a}, 32'h1111);
      set_exm(1, 1, 4, 0);
      tick();
      check("flush_no_count", {16'd0, hazard_cnt}, 1);
      flush = 0;
      set_exm(0, 0, 0, 0);
      tick();
      in_valid = 0;
      tick();
      check("drain_only", {31'd0, out_valid}, 0);

      // A few mixed vectors for the model to cover.
      for (int i = 1; i < 8; i++) begin
         issue(3'(i), 16'(i * 16'h0101), 3'(8 - i), 16'(16'hF000 | i), 1'(i & 1), 16'(i), 3'(i % 6), 3'(i), 1'(i >> 1));
         set_wb(1'(i > 3), 3'(8 - i), 16'hC000 + 16'(i));
         out_ready = 1'(i != 4);
         tick();
      end
      set_wb(0, 0, 0);
      out_ready = 1;

      // Saturation of the stall counter.
      issue(1, 0, 0, 0, 1, 0, 0, 1, 1);
      set_exm(1, 1, 1, 0);
      repeat (32'h10000) tick();
      check("sat_cnt", {16'd0, hazard_cnt}, 32'hFFFF);
      tick();
      check("sat_hold", {16'd0, hazard_cnt}, 32'hFFFF);

      // Reset mid-transfer clears everything without a clock edge.
      set_exm(0, 0, 0, 0);
      issue(2, 16'hABCD, 0, 0, 1, 16'h00EE, 3'b011, 5, 1);
      tick();
      check("pre_reset_a", {16'd0, alu_a}, 32'hABCD);
      out_ready = 0;
      #2;
      rst_n = 0;
      #1;
      check("async_valid", {31'd0, out_valid}, 0);
      check("async_a", {16'd0, alu_a}, 0);
      check("async_b", {16'd0, alu_b}, 0);
      check("async_we", {31'd0, out_rd_we}, 0);
      check("async_cnt", {16'd0, hazard_cnt}, 0);
      #2;
      rst_n = 1;
      in_valid = 0;
      out_ready = 1;
      tick();
      check("ready_after_rerst", {31'd0, in_ready}, 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
